// File: rtl/fu_issue_regfile.sv
// Issue + register-file stage feeding a combinational arithmetic unit: operand fetch with
// distance-1 forwarding, one registered execute stage, write-back with C/N/Z status flags.
module fu_issue_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_da,
  input  logic [AW-1:0]    in_aa,
  input  logic [AW-1:0]    in_ba,
  input  logic             in_mb,
  input  logic [WIDTH-1:0] in_const,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             S1,
  output logic             S0,
  output logic             Cin,
  input  logic [WIDTH-1:0] G,
  input  logic             Cout,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_z,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]  regs_q [NREGS];

  logic              ex_valid_q;
  logic [WIDTH-1:0]  ex_a_q, ex_b_q;
  logic [2:0]        ex_op_q;
  logic [AW-1:0]     ex_da_q;

  logic              wb_valid_q;
  logic [AW-1:0]     wb_addr_q;
  logic [WIDTH-1:0]  wb_data_q;
  logic              flag_c_q, flag_n_q, flag_z_q;

  logic              accept;
  logic [WIDTH-1:0]  opnd_a_d, opnd_b_d;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;

  // Clear sequencer: walks every address once, then hands the file to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(NREGS - 1)) begin
        state_d   = RUN;
        clr_cnt_d = '0;
      end
    end
  end

  assign in_ready = (state_q == RUN) && !rst;
  assign accept   = in_valid && in_ready;

  // The op in EX writes at the same edge this fetch is captured, so its result comes from G.
  always_comb begin
    opnd_a_d = regs_q[in_aa];
    if (ex_valid_q && (in_aa == ex_da_q))
      opnd_a_d = G;
    opnd_b_d = regs_q[in_ba];
    if (ex_valid_q && (in_ba == ex_da_q))
      opnd_b_d = G;
    if (in_mb)
      opnd_b_d = in_const;
  end

  // Single write port shared by the clear walk and write-back; they never overlap.
  always_comb begin
    rf_we    = !rst && ((state_q == CLEAR) || ex_valid_q);
    rf_waddr = ex_da_q;
    rf_wdata = G;
    if (state_q == CLEAR) begin
      rf_waddr = clr_cnt_q;
      rf_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we)
      regs_q[rf_waddr] <= rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_op_q    <= '0;
      ex_da_q    <= '0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_a_q     <= opnd_a_d;
      ex_b_q     <= opnd_b_d;
      ex_op_q    <= in_op;
      ex_da_q    <= in_da;
    end else begin
      ex_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flag_c_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else if (ex_valid_q) begin
      wb_valid_q <= 1'b1;
      wb_addr_q  <= ex_da_q;
      wb_data_q  <= G;
      flag_c_q   <= Cout;
      flag_n_q   <= G[WIDTH-1];
      flag_z_q   <= (G == '0);
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

  assign A             = ex_a_q;
  assign B             = ex_b_q;
  assign {S1, S0, Cin} = ex_op_q;
  assign wb_valid      = wb_valid_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign flag_c        = flag_c_q;
  assign flag_n        = flag_n_q;
  assign flag_z        = flag_z_q;
  assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_fu_issue_regfile.sv
// Bench for fu_issue_regfile: an arithmetic-unit stub closes the loop, and an in-order
// architectural model predicts every write-back, flag set, ready level and register value.
`timescale 1ns/1ps
module tb_fu_issue_regfile;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_da, in_aa, in_ba;
  logic          in_mb;
  logic [W-1:0]  in_const;
  logic [2:0]    in_op;
  logic [W-1:0]  A, B, G;
  logic          S1, S0, Cin, Cout;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          flag_c, flag_n, flag_z;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  int n_vec = 0;
  int n_err = 0;

  fu_issue_regfile #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_da(in_da), .in_aa(in_aa), .in_ba(in_ba), .in_mb(in_mb),
    .in_const(in_const), .in_op(in_op), .A(A), .B(B), .S1(S1), .S0(S0),
    .Cin(Cin), .G(G), .Cout(Cout), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Arithmetic unit behaviour: {S1,S0} picks A, A+B, A+~B or A+all-ones, plus Cin; bit 32 is carry.
  function automatic logic [W:0] au(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] op);
    logic [W:0] y;
    logic [W:0] c;
    c = {{W{1'b0}}, op[0]};
    case (op[2:1])
      2'b00:   y = {1'b0, a} + c;
      2'b01:   y = {1'b0, a} + {1'b0, b} + c;
      2'b10:   y = {1'b0, a} + {1'b0, ~b} + c;
      default: y = {1'b0, a} + {1'b0, {W{1'b1}}} + c;
    endcase
    return y;
  endfunction

  always_comb {Cout, G} = au(A, B, {S1, S0, Cin});

  // Architectural model: registers updated in program order, plus one op in flight.
  logic [W-1:0]  m_reg [N];
  int            clear_left = N;
  bit            p_valid = 0;
  logic [AW-1:0] p_da;
  logic [W:0]    p_res;
  bit            e_wbv = 0;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0]  e_data = '0;
  bit            e_c = 0, e_n = 0, e_z = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit ready;
    ready = !rst && (clear_left == 0);
    if (rst) begin
      p_valid = 0; e_wbv = 0; e_addr = '0; e_data = '0;
      e_c = 0; e_n = 0; e_z = 0; clear_left = N;
    end else begin
      e_wbv = p_valid;
      if (p_valid) begin
        m_reg[p_da] = p_res[W-1:0];
        e_addr = p_da; e_data = p_res[W-1:0];
        e_c = p_res[W]; e_n = p_res[W-1]; e_z = (p_res[W-1:0] == 0);
      end
      p_valid = ready && in_valid;
      if (p_valid) begin
        p_da  = in_da;
        p_res = au(m_reg[in_aa], in_mb ? in_const : m_reg[in_ba], in_op);
      end
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0)
          for (int i = 0; i < N; i++) m_reg[i] = '0;
      end
    end
    @(posedge clk);
    #1;
    chk("in_ready", W'(in_ready), W'(!rst && clear_left == 0));
    chk("wb_valid", W'(wb_valid), W'(e_wbv));
    chk("wb_addr",  W'(wb_addr),  W'(e_addr));
    chk("wb_data",  wb_data,      e_data);
    chk("flags_cnz", W'({flag_c, flag_n, flag_z}), W'({e_c, e_n, e_z}));
    $display("cyc rst=%0d rdy=%0d wbv=%0d wb_addr=%0d wb_data=%h cnz=%0d%0d%0d",
             rst, in_ready, wb_valid, wb_addr, wb_data, flag_c, flag_n, flag_z);
  endtask

  task automatic issue(input logic [AW-1:0] da, input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                       input logic mb, input logic [W-1:0] k, input logic [2:0] op);
    in_valid = 1'b1; in_da = da; in_aa = aa; in_ba = ba; in_mb = mb; in_const = k; in_op = op;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_dbg_model();
    for (int a = 0; a < N; a++) begin
      dbg_addr = AW'(a);
      #1;
      chk($sformatf("dbg_r%0d", a), dbg_data, m_reg[a]);
    end
  endtask

  initial begin
    logic [W-1:0] golden [N];
    golden = '{32'h0, 32'h10, 32'h3, 32'hD, 32'h11, 32'h22, 32'hFFFFFFFF, 32'h0};
    rst = 1'b1; in_valid = 1'b0; in_da = '0; in_aa = '0; in_ba = '0;
    in_mb = 1'b0; in_const = '0; in_op = '0; dbg_addr = '0;

    // Reset and clear walk
    tick(); tick();
    rst = 1'b0;
    idle(N + 1);
    chk_dbg_model();

    // Directed sequence: loads, subtract, forwarding, flags
    issue(3'd1, 3'd0, 3'd0, 1'b1, 32'h10, 3'b010);
    issue(3'd2, 3'd0, 3'd0, 1'b1, 32'h3,  3'b010);
    issue(3'd3, 3'd1, 3'd2, 1'b0, 32'h0,  3'b101);
    issue(3'd4, 3'd1, 3'd0, 1'b1, 32'h0,  3'b001);
    issue(3'd5, 3'd4, 3'd4, 1'b0, 32'h0,  3'b010);
    issue(3'd6, 3'd0, 3'd0, 1'b1, 32'h0,  3'b110);
    issue(3'd7, 3'd1, 3'd1, 1'b0, 32'h0,  3'b101);
    idle(3);
    for (int a = 0; a < N; a++) begin
      dbg_addr = AW'(a);
      #1;
      chk($sformatf("golden_r%0d", a), dbg_data, golden[a]);
    end
    chk("last_flags", W'({flag_c, flag_n, flag_z}), W'(3'b101));

    // Reset while an op sits in EX: its write-back must vanish
    issue(3'd1, 3'd0, 3'd0, 1'b1, 32'h55, 3'b010);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(N + 1);
    chk_dbg_model();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_da = AW'($urandom); in_aa = AW'($urandom); in_ba = AW'($urandom);
      in_mb = $urandom_range(0, 1) == 1;
      in_const = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      in_op = 3'($urandom);
      tick();
    end
    rst = 1'b0;
    idle(N + 2);
    chk_dbg_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
